// File: rtl/singlecycle_pkg.sv
// Shared types and constants for the LSU data-memory responder.
// The legal-strobe table is consulted only when LSU_DMEM_STRB_CHK_EN is defined.
package singlecycle_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int unsigned N_LEGAL_STRB = 8;

  // Byte, aligned halfword, full word, and the empty no-op store.
  localparam logic [3:0] LEGAL_STRB [N_LEGAL_STRB] = '{
    4'b0000, 4'b0001, 4'b0010, 4'b0100,
    4'b1000, 4'b0011, 4'b1100, 4'b1111
  };

  function automatic logic strb_legal(input logic [3:0] strb);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < N_LEGAL_STRB; i++) begin
      if (strb == LEGAL_STRB[i]) ok = 1'b1;
    end
    return ok;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] w;
    w = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) w[8*b +: 8] = new_word[8*b +: 8];
    end
    return w;
  endfunction

endpackage

// File: rtl/lsu_dmem_array.sv
// Word-organised flop memory with per-byte write enables and a combinational
// read port; every word clears to zero on reset.
module lsu_dmem_array #(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_idx,
  input  logic [3:0]       i_be,
  input  logic [31:0]      i_wdata,
  output logic [31:0]      o_rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] mem_d [DEPTH_WORDS];

  always_comb begin
    mem_d = mem_q;
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) mem_d[i_idx][8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) mem_q <= '{default: '0};
    else          mem_q <= mem_d;
  end

  assign o_rdata = mem_q[i_idx];

endmodule

// File: rtl/lsu_dmem_responder.sv
// Single-outstanding LSU data-memory responder with programmable wait states.
// Define LSU_DMEM_STRB_CHK_EN to reject store strobes that are not byte/halfword/word.
//
// Handshakes: a request transfers on a rising edge where i_req_valid and
// o_req_ready are both high; a response transfers on a rising edge where
// o_rsp_valid and i_rsp_ready are both high. Neither valid depends on the
// matching ready, and payloads are held stable while valid waits for ready.
module lsu_dmem_responder
  import singlecycle_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [3:0]  i_req_strb,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [1:0]  o_dbg_state
);

  localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_INIT_I = (WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0;
  localparam logic [3:0]  CNT_INIT   = CNT_INIT_I[3:0];

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         strb_q, strb_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               oor_q, oor_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               accept;
  logic               enter_resp;
  logic               req_oor;
  logic               op_we, op_oor, strb_bad, wr_ok;
  logic [IDX_W-1:0]   op_idx;
  logic [3:0]         op_strb;
  logic [31:0]        op_wdata;
  logic [31:0]        mem_word;
  logic [1:0]         unused_addr_lsb;

  assign unused_addr_lsb = i_req_addr[1:0];
  assign req_oor = |i_req_addr[31:IDX_W+2];
  assign accept  = (state_q == S_IDLE) && i_req_valid;

  // With zero wait states the access happens on the accepting edge itself,
  // so the operation comes straight from the request port rather than the latches.
  always_comb begin
    if (state_q == S_IDLE) begin
      op_we    = i_req_we;
      op_idx   = i_req_addr[IDX_W+1:2];
      op_strb  = i_req_strb;
      op_wdata = i_req_wdata;
      op_oor   = req_oor;
    end else begin
      op_we    = we_q;
      op_idx   = idx_q;
      op_strb  = strb_q;
      op_wdata = wdata_q;
      op_oor   = oor_q;
    end
  end

`ifdef LSU_DMEM_STRB_CHK_EN
  assign strb_bad = op_we && !op_oor && !strb_legal(op_strb);
`else
  assign strb_bad = 1'b0;
`endif

  assign wr_ok = op_we && !op_oor && !strb_bad;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    idx_d      = idx_q;
    strb_d     = strb_q;
    wdata_d    = wdata_q;
    oor_d      = oor_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          we_d    = i_req_we;
          idx_d   = i_req_addr[IDX_W+1:2];
          strb_d  = i_req_strb;
          wdata_d = i_req_wdata;
          oor_d   = req_oor;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Response payload is captured once, on the commit edge, and then frozen.
    if (enter_resp) begin
      if (op_oor)     rdata_d = '0;
      else if (wr_ok) rdata_d = merge_lanes(mem_word, op_wdata, op_strb);
      else            rdata_d = mem_word;
      err_d = op_oor || strb_bad;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      strb_q  <= '0;
      wdata_q <= '0;
      oor_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      strb_q  <= strb_d;
      wdata_q <= wdata_d;
      oor_q   <= oor_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  lsu_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_we    (enter_resp && wr_ok),
    .i_idx   (op_idx),
    .i_be    (op_strb),
    .i_wdata (op_wdata),
    .o_rdata (mem_word)
  );

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = (state_q == S_RESP);
  assign o_rsp_rdata = rdata_q;
  assign o_rsp_err   = err_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lsu_dmem_responder.sv
// Directed bench for lsu_dmem_responder: a vector table of sequential
// transactions plus hand-written hold, back-pressure and reset sequences.
module tb_lsu_dmem_responder;
  import singlecycle_pkg::*;

  localparam int unsigned DEPTH   = 256;
  localparam int unsigned WAITC   = 2;
  localparam int          EXP_LAT = WAITC + 1;
  localparam int          BOUND   = 50;

  logic        i_clk, i_rst_n;
  logic        i_req_valid, o_req_ready, i_req_we;
  logic [31:0] i_req_addr, i_req_wdata;
  logic [3:0]  i_req_strb;
  logic        o_rsp_valid, i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [1:0]  o_dbg_state;

  lsu_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_strb  (i_req_strb),
    .i_req_wdata (i_req_wdata),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_rdata (o_rsp_rdata),
    .o_rsp_err   (o_rsp_err),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int N_VEC = 15;
  vec_t vecs [N_VEC];

  logic [31:0] exp_q[$];
  logic        exp_err_q[$];
  int          n_total;
  int          n_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", name, act, exp);
    end
  endtask

  // Driver: one full transaction with i_rsp_ready held high.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] wdata, output logic [31:0] rd,
                         output logic er, output int lat);
    int g;
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_we    = we;
    i_req_addr  = addr;
    i_req_strb  = strb;
    i_req_wdata = wdata;
    i_rsp_ready = 1'b1;
    g = 0;
    while (!o_req_ready && g < BOUND) begin
      @(negedge i_clk);
      g++;
    end
    check("req_ready_wait", {31'd0, o_req_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < BOUND) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    check("rsp_valid_wait", {31'd0, o_rsp_valid}, 32'd1);
    rd = o_rsp_rdata;
    er = o_rsp_err;
    @(posedge i_clk);
    #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] held_rdata;

  initial begin
    n_total     = 0;
    n_bad       = 0;
    i_rst_n     = 1'b0;
    i_req_valid = 1'b0;
    i_req_we    = 1'b0;
    i_req_addr  = '0;
    i_req_strb  = '0;
    i_req_wdata = '0;
    i_rsp_ready = 1'b0;

    vecs[0]  = '{1'b1, 32'h0000_0010, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'b0000, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0012, 4'b1100, 32'h55AA_0000, 32'h55AA_BEEF, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0013, 4'b0000, 32'h0,         32'h55AA_BEEF, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0400, 4'b0000, 32'h0,         32'h0,         1'b1};
    vecs[5]  = '{1'b1, 32'h0000_0400, 4'b1111, 32'h1234_5678, 32'h0,         1'b1};
    vecs[6]  = '{1'b0, 32'h0000_0000, 4'b0000, 32'h0,         32'h0,         1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0014, 4'b0000, 32'hFFFF_FFFF, 32'h0,         1'b0};
`ifdef LSU_DMEM_STRB_CHK_EN
    vecs[8]  = '{1'b1, 32'h0000_0014, 4'b0101, 32'hA1B2_C3D4, 32'h0,         1'b1};
    vecs[9]  = '{1'b0, 32'h0000_0014, 4'b0000, 32'h0,         32'h0,         1'b0};
`else
    vecs[8]  = '{1'b1, 32'h0000_0014, 4'b0101, 32'hA1B2_C3D4, 32'h00B2_00D4, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0014, 4'b0000, 32'h0,         32'h00B2_00D4, 1'b0};
`endif
    vecs[10] = '{1'b1, 32'h0000_03FC, 4'b0011, 32'h0000_CAFE, 32'h0000_CAFE, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_03FC, 4'b0000, 32'h0,         32'h0000_CAFE, 1'b0};
    vecs[12] = '{1'b0, 32'h8000_0010, 4'b0000, 32'h0,         32'h0,         1'b1};
    vecs[13] = '{1'b1, 32'h0000_0018, 4'b1000, 32'hAB00_0000, 32'hAB00_0000, 1'b0};
    vecs[14] = '{1'b1, 32'h0000_0018, 4'b0001, 32'h0000_00CD, 32'hAB00_00CD, 1'b0};

    // Reset values while reset is held across clock edges
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("rst_rdata", o_rsp_rdata, 32'd0);
    check("rst_err", {31'd0, o_rsp_err}, 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;

    // Table-driven transactions through the scoreboard
    for (int i = 0; i < N_VEC; i++) begin
      exp_q.push_back(vecs[i].exp_rdata);
      exp_err_q.push_back(vecs[i].exp_err);
      run_txn(vecs[i].we, vecs[i].addr, vecs[i].strb, vecs[i].wdata, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, exp_q.pop_front());
      check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, exp_err_q.pop_front()});
      check($sformatf("vec%0d_latency", i), lat, EXP_LAT);
    end

    // Back-pressure: response held 4 cycles while a second request waits
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_addr  = 32'h0000_0030;
    i_req_strb  = 4'b1111;
    i_req_wdata = 32'h0BAD_F00D;
    i_rsp_ready = 1'b0;
    check("hold_ready_before", {31'd0, o_req_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_req_we = 1'b0;
    i_req_wdata = 32'hFFFF_FFFF;
    lat = 1;
    while (!o_rsp_valid && lat < BOUND) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    check("hold_latency", lat, EXP_LAT);
    held_rdata = o_rsp_rdata;
    check("hold_first_rdata", held_rdata, 32'h0BAD_F00D);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("hold%0d_valid", c), {31'd0, o_rsp_valid}, 32'd1);
      check($sformatf("hold%0d_req_ready", c), {31'd0, o_req_ready}, 32'd0);
      check($sformatf("hold%0d_rdata", c), o_rsp_rdata, 32'h0BAD_F00D);
      check($sformatf("hold%0d_err", c), {31'd0, o_rsp_err}, 32'd0);
      @(posedge i_clk);
      #1;
    end
    @(negedge i_clk);
    check("hs_req_ready_low", {31'd0, o_req_ready}, 32'd0);
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    check("idle_after_hs_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("idle_after_hs_ready", {31'd0, o_req_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    check("pending_accepted", {30'd0, o_dbg_state}, {30'd0, S_WAIT});
    lat = 1;
    while (!o_rsp_valid && lat < BOUND) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
    check("pending_load_rdata", o_rsp_rdata, 32'h0BAD_F00D);
    check("pending_load_err", {31'd0, o_rsp_err}, 32'd0);
    @(posedge i_clk);
    #1;

    // Reset during WAIT of a store: aborted, memory cleared
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_we    = 1'b1;
    i_req_addr  = 32'h0000_0020;
    i_req_strb  = 4'b1111;
    i_req_wdata = 32'h1111_2222;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    check("abort_in_wait", {30'd0, o_dbg_state}, {30'd0, S_WAIT});
    #2;
    i_rst_n = 1'b0;
    #1;
    check("abort_req_ready", {31'd0, o_req_ready}, 32'd1);
    check("abort_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check("abort_rdata", o_rsp_rdata, 32'd0);
    check("abort_err", {31'd0, o_rsp_err}, 32'd0);
    check("abort_state", {30'd0, o_dbg_state}, {30'd0, S_IDLE});
    @(negedge i_clk);
    i_rst_n = 1'b1;
    run_txn(1'b0, 32'h0000_0020, 4'b0000, 32'h0, rd, er, lat);
    check("abort_load20_rdata", rd, 32'd0);
    run_txn(1'b0, 32'h0000_0010, 4'b0000, 32'h0, rd, er, lat);
    check("rst_cleared_10", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
